// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM generator / capture pair.
//   PWM_CNT_W        default width of the measurement counters and result ports
//   pwm_cap_state_t  capture FSM state encoding
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int PWM_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } pwm_cap_state_t;

endpackage

// File: rtl/pwm_in_conditioner.sv
// -----------------------------------------------------------------------------
// pwm_in_conditioner
// Brings the asynchronous PWM pin into the clk domain and produces a clean
// level plus a single-cycle rising-edge strobe.
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset
//   pwm_in  in   asynchronous PWM input
//   s       out  conditioned input level
//   rise    out  s is 1 this cycle and was 0 the cycle before
// Optional build macro: PWM_GLITCH_FILTER_EN inserts a FILT_LEN-cycle
// persistence filter after the synchronizer.
// -----------------------------------------------------------------------------
module pwm_in_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   s_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PWM_GLITCH_FILTER_EN
    localparam int FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;

    // fcnt counts consecutive samples that disagree with the filtered level;
    // the level only flips on the FILT_LEN-th disagreeing sample in a row.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync_out != filt_q) begin
            if (fcnt_q == FW'(FILT_LEN - 1)) begin
                filt_d = ~filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign s = filt_q;
`else
    // Filter length is meaningless without the filter.
    logic unused_filt_len;
    assign unused_filt_len = (FILT_LEN != 0);
    assign s = sync_out;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q <= 1'b0;
        end else begin
            s_q <= s;
        end
    end

    assign rise = s & ~s_q;

endmodule

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
// Measures an incoming PWM waveform: high time and rising-to-rising period in
// clk cycles, reported once per period, with stuck-input detection.
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   ena         in   measurement enable; low forces IDLE and discards progress
//   pwm_in      in   asynchronous PWM input
//   high_cnt    out  high time of the last complete period
//   period_cnt  out  period of the last complete period
//   meas_valid  out  one-cycle pulse when high_cnt/period_cnt update
//   busy        out  measurement in progress (HIGH or LOW)
//   timeout     out  sticky; period counter saturated without a new rise
//   level       out  conditioned level captured at timeout (1 = stuck high)
// Optional build macro: PWM_GLITCH_FILTER_EN (see pwm_in_conditioner).
// -----------------------------------------------------------------------------
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             busy,
    output logic             timeout,
    output logic             level
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic s;
    logic rise;

    pwm_in_conditioner #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .s      (s),
        .rise   (rise)
    );

    pwm_cap_state_t   state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             mv_q, mv_d;
    logic             tmo_q, tmo_d;
    logic             lvl_q, lvl_d;

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        pcnt_d  = pcnt_q;
        high_d  = high_q;
        per_d   = per_q;
        mv_d    = 1'b0;
        tmo_d   = tmo_q;
        lvl_d   = lvl_q;

        if (!ena) begin
            state_d = IDLE;
            hcnt_d  = '0;
            pcnt_d  = '0;
            tmo_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    hcnt_d  = '0;
                    pcnt_d  = '0;
                end
                ARM: begin
                    // The partial period before the first rise is never measured.
                    if (rise) begin
                        state_d = HIGH;
                        hcnt_d  = CNT_ONE;
                        pcnt_d  = CNT_ONE;
                    end
                end
                HIGH: begin
                    // A rise cannot occur while s is already high, so only
                    // saturation and the falling edge matter here.
                    if (pcnt_q == CNT_MAX) begin
                        state_d = ARM;
                        tmo_d   = 1'b1;
                        lvl_d   = s;
                        hcnt_d  = '0;
                        pcnt_d  = '0;
                    end else if (!s) begin
                        state_d = LOW;
                        pcnt_d  = pcnt_q + 1'b1;
                    end else begin
                        hcnt_d  = hcnt_q + 1'b1;
                        pcnt_d  = pcnt_q + 1'b1;
                    end
                end
                LOW: begin
                    // Rise is checked first so a rise coinciding with
                    // saturation still produces a result.
                    if (rise) begin
                        state_d = HIGH;
                        high_d  = hcnt_q;
                        per_d   = pcnt_q;
                        mv_d    = 1'b1;
                        tmo_d   = 1'b0;
                        hcnt_d  = CNT_ONE;
                        pcnt_d  = CNT_ONE;
                    end else if (pcnt_q == CNT_MAX) begin
                        state_d = ARM;
                        tmo_d   = 1'b1;
                        lvl_d   = s;
                        hcnt_d  = '0;
                        pcnt_d  = '0;
                    end else begin
                        pcnt_d  = pcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                    pcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            pcnt_q  <= '0;
            high_q  <= '0;
            per_q   <= '0;
            mv_q    <= 1'b0;
            tmo_q   <= 1'b0;
            lvl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            pcnt_q  <= pcnt_d;
            high_q  <= high_d;
            per_q   <= per_d;
            mv_q    <= mv_d;
            tmo_q   <= tmo_d;
            lvl_q   <= lvl_d;
        end
    end

    assign high_cnt   = high_q;
    assign period_cnt = per_q;
    assign meas_valid = mv_q;
    assign busy       = (state_q == HIGH) || (state_q == LOW);
    assign timeout    = tmo_q;
    assign level      = lvl_q;

endmodule
